sub_result_stage: RTL and testbench
===================================

# sub_result_stage

Registered result stage directly downstream of the 8-bit subtractor (`full_sub_8b`). It accepts the 9-bit subtract result (8-bit `diff` plus `borrow`) together with the operand sign bits over a valid/ready handshake. It derives the status flags C, Z, N and V, and buffers result plus flags in a DEPTH-entry FIFO. Entries are presented to the ALU writeback/output logic over a second valid/ready handshake.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `clk  in  1`: clock; all state updates on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `in_valid  in  1`: upstream result valid.
- `in_ready  out  1`: stage can accept an entry.
- `in_diff  in  8`: subtractor `diff[7:0]`.
- `in_borrow  in  1`: subtractor `borrow` (`diff[8]`).
- `in_a_msb  in  1`: bit 7 of minuend a.
- `in_b_msb  in  1`: bit 7 of subtrahend b.
- `out_valid  out  1`: head entry valid.
- `out_ready  in  1`: downstream accepts the head entry.
- `out_diff  out  8`: head entry result.
- `out_flags  out  4`: head entry flags, {V,N,Z,C}.
- `count  out  $clog2(DEPTH)+1`: current occupancy, 0..DEPTH.
- `sticky_clr  in  1`: clears the sticky flags.
- `sticky_flags  out  4`: accumulated {V,N,Z,C}.

## Operation
- Push when `in_valid && in_ready`; pop when `out_valid && out_ready`.
- Flags are computed at push from the inputs:
  - C = `in_borrow`
  - Z = (`in_diff` == 8'h00)
  - N = `in_diff[7]`
  - V = (`in_a_msb` != `in_b_msb`) && (`in_diff[7]` != `in_a_msb`)
- Stored entry is 12 bits: {flags, diff}.
- Write and read pointers are `$clog2(DEPTH)` bits and wrap from DEPTH-1 to 0.
- Occupancy update:
  - push only: `count` +1.
  - pop only: `count` −1.
  - push and pop in the same cycle: `count` unchanged; both pointers advance.
- `in_ready` = (`count` != DEPTH). When full, no push occurs, even if a pop happens in the same cycle; there is no full-bypass.
- `out_valid` = (`count` != 0). No empty-bypass: a pushed entry is never presented in the cycle it is pushed.
- `out_diff` and `out_flags` are 0 whenever `out_valid` is 0. While `out_valid` is 1 they show the head entry.
- Head entry and `out_valid` are held stable until popped.
- `in_valid` with `in_ready` = 0 is dropped by this stage; upstream must hold its data.
- Entry order is strict FIFO. No data is modified after push.

## Timing
- Reset values (cycle after `rst` sampled high): `count`=0, pointers=0, `out_valid`=0, `in_ready`=1, `out_diff`=0, `out_flags`=0, `sticky_flags`=0.
- `rst` takes priority over push, pop and `sticky_clr`. Reset mid-operation discards all entries, and no pop is reported in that cycle.
- Latency: an entry pushed at edge N drives `out_valid`=1 and its data after edge N, i.e. in cycle N+1.
- Throughput: one push and one pop per cycle when 0 < `count` < DEPTH.
- `in_ready`, `out_valid`, `out_diff` and `out_flags` are functions of registered state only; there is no combinational path from `in_*` or `out_ready`.

## Configuration
- Macro `SUB_RESULT_STICKY_EN`, when defined:
  - `sticky_flags` accumulates (OR) the flags of every pushed entry.
  - `sticky_clr` clears it.
  - `sticky_clr` and a push in the same cycle: `sticky_flags` = flags of that pushed entry only.
- Not defined: `sticky_flags` is tied to 4'b0000 and `sticky_clr` is ignored. FIFO behaviour is identical.

## Test plan
- Basic push: a=8'h05, b=8'h03 (diff 8'h02, borrow 0, msbs 0/0) pushed with `out_ready`=1.
  - Next cycle: `out_valid`=1, `out_diff`=8'h02, `out_flags`=4'b0000.
  - Following cycle: `count`=0.
- Borrow and negative: a=8'h03, b=8'h05 (diff 8'hFE, borrow 1) -> `out_flags`=4'b0101.
- Zero: a=b=8'hFF (diff 8'h00, borrow 0) -> `out_flags`=4'b0010.
- Overflow: a=8'h80, b=8'h01 (diff 8'h7F, borrow 0) -> `out_flags`=4'b1000. With the macro, `sticky_flags` after this sequence = 4'b1111; after `sticky_clr` = 4'b0000.
- Full: hold `out_ready`=0 and push 4 entries -> `count`=4, `in_ready`=0.
  - A 5th `in_valid` held 3 cycles is not accepted.
  - Then assert `out_ready` with `in_valid` still high: first pop returns entry 1; the 5th entry is pushed the cycle after the pop; all 5 drain in order.
- Reset mid-operation: with `count`=3, assert `rst` for one cycle together with `in_valid` and `out_ready` -> next cycle `count`=0, `out_valid`=0, `out_diff`=0, `sticky_flags`=0, `in_ready`=1.

Source files
------------

// File: rtl/sub_result_stage_if.sv
// sub_result_stage_if: groups the upstream (subtractor -> stage) and
// downstream (stage -> writeback) valid/ready handshakes of sub_result_stage.
// slave  : view taken by the stage itself.
// master : view taken by the agent driving the stage (producer and consumer).
interface sub_result_stage_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_diff;
   logic       in_borrow;
   logic       in_a_msb;
   logic       in_b_msb;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_diff;
   logic [3:0] out_flags;

   modport slave (
      input  in_valid, in_diff, in_borrow, in_a_msb, in_b_msb, out_ready,
      output in_ready, out_valid, out_diff, out_flags
   );

   modport master (
      output in_valid, in_diff, in_borrow, in_a_msb, in_b_msb, out_ready,
      input  in_ready, out_valid, out_diff, out_flags
   );
endinterface

// File: rtl/sub_result_stage.sv
// sub_result_stage: registered result stage behind full_sub_8b.
// Derives {V,N,Z,C} from the subtract result at push time and buffers
// {flags, diff} in a DEPTH-entry FIFO (no full- or empty-bypass).
// Optional macro SUB_RESULT_STICKY_EN: sticky_flags ORs the flags of every
// pushed entry; sticky_clr clears it. Undefined: sticky_flags is tied to 0.
module sub_result_stage #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   sub_result_stage_if.slave        bus,
   output logic [$clog2(DEPTH):0]   count,
   input  logic                     sticky_clr,
   output logic [3:0]               sticky_flags
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [11:0]   mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic          push, pop;
   logic [3:0]    flags_in;
   logic [11:0]   head;

   // Handshake status and head presentation from registered state only
   always_comb begin
      bus.in_ready  = (count_q != FULL_CNT);
      bus.out_valid = (count_q != '0);
      head          = mem_q[rptr_q];
      bus.out_diff  = bus.out_valid ? head[7:0]  : '0;
      bus.out_flags = bus.out_valid ? head[11:8] : '0;
      count         = count_q;
   end

   // Flag derivation {V,N,Z,C} from the incoming subtract result
   always_comb begin
      flags_in[0] = bus.in_borrow;
      flags_in[1] = (bus.in_diff == 8'h00);
      flags_in[2] = bus.in_diff[7];
      flags_in[3] = (bus.in_a_msb != bus.in_b_msb) && (bus.in_diff[7] != bus.in_a_msb);
   end

   // Next-state for pointers and occupancy
   always_comb begin
      push    = bus.in_valid && bus.in_ready;
      pop     = bus.out_valid && bus.out_ready;
      wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers; reset discards all entries
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Entry storage; contents are only meaningful where count covers them
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wptr_q] <= {flags_in, bus.in_diff};
      end
   end

`ifdef SUB_RESULT_STICKY_EN
   logic [3:0] sticky_q;

   // Sticky accumulation; a clear coinciding with a push keeps only that entry's flags
   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_q <= '0;
      end else if (sticky_clr) begin
         sticky_q <= push ? flags_in : 4'b0000;
      end else if (push) begin
         sticky_q <= sticky_q | flags_in;
      end
   end

   assign sticky_flags = sticky_q;
`else
   logic unused_sticky_clr;

   assign unused_sticky_clr = sticky_clr;
   assign sticky_flags      = '0;
`endif

endmodule

// File: tb/tb_sub_result_stage.sv
// Directed bench for sub_result_stage (DEPTH = 4). Inputs change 1 ns after
// the rising edge and outputs are checked at that same point.
module tb_sub_result_stage;

   logic       clk = 1'b0;
   logic       rst;
   logic       sticky_clr;
   logic [2:0] count;
   logic [3:0] sticky_flags;
   int         n_vec = 0;
   int         n_err = 0;

   sub_result_stage_if bus ();

   sub_result_stage #(.DEPTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .count        (count),
      .sticky_clr   (sticky_clr),
      .sticky_flags (sticky_flags)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a - b to the stage as full_sub_8b would produce it
   task automatic drive_sub(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] r;
      r             = {1'b0, a} - {1'b0, b};
      bus.in_diff   = r[7:0];
      bus.in_borrow = r[8];
      bus.in_a_msb  = a[7];
      bus.in_b_msb  = b[7];
      bus.in_valid  = 1'b1;
   endtask

   initial begin
      rst           = 1'b1;
      sticky_clr    = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_diff   = '0;
      bus.in_borrow = 1'b0;
      bus.in_a_msb  = 1'b0;
      bus.in_b_msb  = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_count",    12'(count), 12'h0);
      check("rst_in_ready", 12'(bus.in_ready), 12'h1);
      check("rst_out_valid",12'(bus.out_valid), 12'h0);
      check("rst_out_diff", 12'(bus.out_diff), 12'h0);
      check("rst_out_flags",12'(bus.out_flags), 12'h0);
      check("rst_sticky",   12'(sticky_flags), 12'h0);

      // Basic push 05-03
      bus.out_ready = 1'b1;
      drive_sub(8'h05, 8'h03);
      tick();
      bus.in_valid = 1'b0;
      check("basic_valid", 12'(bus.out_valid), 12'h1);
      check("basic_diff",  12'(bus.out_diff), 12'h02);
      check("basic_flags", 12'(bus.out_flags), 12'h0);
      check("basic_count1",12'(count), 12'h1);
      tick();
      check("basic_count0",12'(count), 12'h0);
      check("basic_empty_diff", 12'(bus.out_diff), 12'h0);

      // Borrow and negative 03-05
      drive_sub(8'h03, 8'h05);
      tick();
      bus.in_valid = 1'b0;
      check("borrow_diff",  12'(bus.out_diff), 12'hFE);
      check("borrow_flags", 12'(bus.out_flags), 12'b0101);
      tick();

      // Zero FF-FF
      drive_sub(8'hFF, 8'hFF);
      tick();
      bus.in_valid = 1'b0;
      check("zero_diff",  12'(bus.out_diff), 12'h00);
      check("zero_flags", 12'(bus.out_flags), 12'b0010);
      tick();

      // Overflow 80-01
      drive_sub(8'h80, 8'h01);
      tick();
      bus.in_valid = 1'b0;
      check("ovf_diff",  12'(bus.out_diff), 12'h7F);
      check("ovf_flags", 12'(bus.out_flags), 12'b1000);
      tick();
      check("ovf_drained", 12'(count), 12'h0);
`ifdef SUB_RESULT_STICKY_EN
      check("sticky_acc", 12'(sticky_flags), 12'b1111);
`else
      check("sticky_acc", 12'(sticky_flags), 12'b0000);
`endif
      sticky_clr = 1'b1;
      tick();
      sticky_clr = 1'b0;
      check("sticky_clr", 12'(sticky_flags), 12'b0000);

      // Fill: E1=10-01 (0F,0000) E2=01-02 (FF,0101) E3=7F-FF (80,1101) E4=55-55 (00,0010)
      bus.out_ready = 1'b0;
      drive_sub(8'h10, 8'h01); tick();
      drive_sub(8'h01, 8'h02); tick();
      drive_sub(8'h7F, 8'hFF); tick();
      drive_sub(8'h55, 8'h55); tick();
      check("full_count",    12'(count), 12'h4);
      check("full_in_ready", 12'(bus.in_ready), 12'h0);

      // E5=A0-20 (80,0100) held three cycles while full
      drive_sub(8'hA0, 8'h20);
      tick(); tick(); tick();
      check("full_hold_count", 12'(count), 12'h4);
      check("full_head_e1",    {bus.out_flags, bus.out_diff}, {4'b0000, 8'h0F});

      // Drain with E5 still offered: pop E1 alone, then pop E2 + push E5
      bus.out_ready = 1'b1;
      tick();
      check("pop1_count", 12'(count), 12'h3);
      check("head_e2",    {bus.out_flags, bus.out_diff}, {4'b0101, 8'hFF});
      tick();
      bus.in_valid = 1'b0;
      check("pop2_push5_count", 12'(count), 12'h3);
      check("head_e3",    {bus.out_flags, bus.out_diff}, {4'b1101, 8'h80});
      tick();
      check("head_e4",    {bus.out_flags, bus.out_diff}, {4'b0010, 8'h00});
      tick();
      check("head_e5",    {bus.out_flags, bus.out_diff}, {4'b0100, 8'h80});
      tick();
      check("drain_count", 12'(count), 12'h0);
      check("drain_valid", 12'(bus.out_valid), 12'h0);

      // sticky_clr together with a push keeps only that entry's flags (03-05 -> 0101)
      sticky_clr = 1'b1;
      drive_sub(8'h03, 8'h05);
      tick();
      sticky_clr   = 1'b0;
      bus.in_valid = 1'b0;
`ifdef SUB_RESULT_STICKY_EN
      check("sticky_clr_push", 12'(sticky_flags), 12'b0101);
`else
      check("sticky_clr_push", 12'(sticky_flags), 12'b0000);
`endif
      tick();
      check("clr_push_drained", 12'(count), 12'h0);

      // Reset mid-operation with three entries, in_valid and out_ready high
      bus.out_ready = 1'b0;
      drive_sub(8'h09, 8'h04); tick();
      drive_sub(8'h00, 8'h01); tick();
      drive_sub(8'h80, 8'h80); tick();
      check("pre_rst_count", 12'(count), 12'h3);
      rst           = 1'b1;
      bus.out_ready = 1'b1;
      drive_sub(8'h44, 8'h11);
      tick();
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      check("mid_rst_count",    12'(count), 12'h0);
      check("mid_rst_valid",    12'(bus.out_valid), 12'h0);
      check("mid_rst_diff",     12'(bus.out_diff), 12'h0);
      check("mid_rst_sticky",   12'(sticky_flags), 12'h0);
      check("mid_rst_in_ready", 12'(bus.in_ready), 12'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
